// File: rtl/snake_vram_pkg.sv
// Shared constants and types for the snake tile RAM: grid geometry, tile codes and the
// arbiter state encoding.
package snake_vram_pkg;

  localparam int unsigned GRID_W = 40;
  localparam int unsigned GRID_H = 30;
  localparam int unsigned DEPTH  = GRID_W * GRID_H;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 2;

  localparam logic [DATA_W-1:0] TILE_EMPTY = 2'd0;
  localparam logic [DATA_W-1:0] TILE_SNAKE = 2'd1;
  localparam logic [DATA_W-1:0] TILE_FOOD  = 2'd2;
  localparam logic [DATA_W-1:0] TILE_WALL  = 2'd3;

  typedef enum logic {
    StIdle,
    StClear
  } arb_state_e;

endpackage

// File: rtl/vram_clear_counter.sv
// Tile address counter for the clear sequencer: advances on enable, wraps to zero after the
// last tile, and can be restarted synchronously.
module vram_clear_counter #(
  parameter int unsigned ADDR_W = snake_vram_pkg::ADDR_W,
  parameter int unsigned DEPTH  = snake_vram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] count_q;

  assign count_o = count_q;
  assign last_o  = (count_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (restart_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= last_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port tile RAM arbiter: display reads always win, then the clear sequencer, then the
// game-logic writer. One RAM access per clock.
module vram_arbiter #(
  parameter int unsigned        ADDR_W         = snake_vram_pkg::ADDR_W,
  parameter int unsigned        DATA_W         = snake_vram_pkg::DATA_W,
  parameter int unsigned        DEPTH          = snake_vram_pkg::DEPTH,
  parameter logic [DATA_W-1:0]  CLEAR_VAL      = DATA_W'(snake_vram_pkg::TILE_EMPTY),
  parameter bit                 WRITE_IN_BLANK = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import snake_vram_pkg::*;

  arb_state_e        state_q;
  logic              clr_busy_q;
  logic              clr_done_q;
  logic              disp_pend_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;
  logic              clr_step;
  logic              clr_restart;
  logic              wr_enable;
  logic              wr_accept;

  assign wr_enable   = WRITE_IN_BLANK ? vblank : 1'b1;
  // rst_n gating keeps the handshake closed while reset is asserted
  assign wr_ready    = rst_n && (state_q == StIdle) && !disp_req && !clr_start && wr_enable;
  assign wr_accept   = wr_valid && wr_ready;
  assign clr_step    = (state_q == StClear) && !disp_req;
  assign clr_restart = (state_q == StIdle) && clr_start;

  vram_clear_counter #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_clear_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (clr_step),
    .restart_i(clr_restart),
    .count_o  (clr_addr),
    .last_o   (clr_last)
  );

  // Grant mux
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (disp_req) begin
      ram_addr = disp_addr;
    end else if (state_q == StClear) begin
      ram_addr  = clr_addr;
      ram_we    = 1'b1;
      ram_wdata = CLEAR_VAL;
    end else if (wr_accept) begin
      // Off-grid writes complete the handshake but never reach the RAM
      ram_addr  = wr_addr;
      ram_we    = 32'(wr_addr) < DEPTH;
      ram_wdata = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q    <= StClear;
            clr_busy_q <= 1'b1;
          end
        end
        StClear: begin
          if (clr_step && clr_last) begin
            state_q    <= StIdle;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Display read pipeline: RAM output arrives one clock after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_pend_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      disp_pend_q  <= disp_req;
      disp_valid_q <= disp_pend_q;
      if (disp_pend_q) begin
        disp_data_q <= ram_rdata;
      end
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;

endmodule
